// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline sequencer.
//   pipeState_t      : RUN / DRAIN / HALTED sequencer states
//   DRAIN_CYCLES_DEF : default drain length after a decoded HLT (EX, MEM, WB)
//   RA_W_DEF         : default register address width
//   CNT_W            : width of the optional performance counters
//   satInc()         : saturating increment used by the performance counters
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipeState_t;

  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int RA_W_DEF         = 3;
  localparam int CNT_W            = 16;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counters stick at all-ones instead of wrapping, so a long stall storm
  // never reads back as a small number.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v,
                                              input logic             inc);
    if (inc && (v != '1)) begin
      return v + CNT_ONE;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_lu_hazard.sv
// -----------------------------------------------------------------------------
// lu_hazard
// Combinational load-use hazard detect: the instruction in EX is a load that
// writes a register which the instruction in ID actually reads.
// Ports:
//   i_load_ex, i_regwrite_ex   : EX instruction loads from memory / writes a reg
//   i_regwrite_adr_ex [RA_W]   : EX destination register
//   i_rs_id, i_rt_id  [RA_W]   : ID source registers
//   i_rs_used_id, i_rt_used_id : ID source is really read
//   o_lu                       : load-use hazard present this cycle
// -----------------------------------------------------------------------------
module lu_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic            i_load_ex,
  input  logic            i_regwrite_ex,
  input  logic [RA_W-1:0] i_regwrite_adr_ex,
  input  logic [RA_W-1:0] i_rs_id,
  input  logic [RA_W-1:0] i_rt_id,
  input  logic            i_rs_used_id,
  input  logic            i_rt_used_id,
  output logic            o_lu
);

  logic w_rsMatch;
  logic w_rtMatch;

  // A source only counts when the ID instruction really reads it; unused
  // fields may hold leftover bits that happen to equal the destination.
  assign w_rsMatch = i_rs_used_id & (i_rs_id == i_regwrite_adr_ex);
  assign w_rtMatch = i_rt_used_id & (i_rt_id == i_regwrite_adr_ex);

  assign o_lu = i_load_ex & i_regwrite_ex & (w_rsMatch | w_rtMatch);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencer of the 16-bit five-stage core. Produces the PC enable and
// the enable/flush pair of every pipeline register, arbitrating data-memory
// wait, taken-jump flush, load-use stall and the HLT drain sequence.
// Optional feature macro: PIPE_PERF_EN (adds saturating stall/flush counters).
// Ports:
//   i_clk                      : clock, rising edge
//   i_reset                    : asynchronous reset, active LOW
//   i_jump                     : taken branch/jump resolved in EX
//   i_mem_wait                 : data memory not ready, freeze everything
//   i_load_ex, i_regwrite_ex, i_regwrite_adr_ex : EX writeback info
//   i_rs_id, i_rt_id, i_rs_used_id, i_rt_used_id : ID source operands
//   i_halt_id                  : HLT decoded in ID
//   i_restart                  : leave HALTED
//   o_en_pc, o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb : enables
//   o_flush_ifid .. o_flush_memwb : load bubble (wins over hold)
//   o_flushed                  : registered, high the cycle after a jump flush
//   o_is_halt                  : registered, high while HALTED
//   o_stall_cnt, o_flush_cnt   : performance counters (PIPE_PERF_EN only)
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int RA_W         = RA_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_jump,
  input  logic             i_mem_wait,
  input  logic             i_load_ex,
  input  logic             i_regwrite_ex,
  input  logic [RA_W-1:0]  i_regwrite_adr_ex,
  input  logic [RA_W-1:0]  i_rs_id,
  input  logic [RA_W-1:0]  i_rt_id,
  input  logic             i_rs_used_id,
  input  logic             i_rt_used_id,
  input  logic             i_halt_id,
  input  logic             i_restart,
  output logic             o_en_pc,
  output logic             o_en_ifid,
  output logic             o_en_idex,
  output logic             o_en_exmem,
  output logic             o_en_memwb,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_flush_exmem,
  output logic             o_flush_memwb,
  output logic             o_flushed,
  output logic             o_is_halt
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

  pipeState_t     r_state;
  logic [DCW-1:0] r_drainCnt;
  logic           r_flushed;
  logic           r_isHalt;
  logic           w_lu;
  logic           w_jumpTaken;

  lu_hazard #(
    .RA_W(RA_W)
  ) uLuHazard (
    .i_load_ex         (i_load_ex),
    .i_regwrite_ex     (i_regwrite_ex),
    .i_regwrite_adr_ex (i_regwrite_adr_ex),
    .i_rs_id           (i_rs_id),
    .i_rt_id           (i_rt_id),
    .i_rs_used_id      (i_rs_used_id),
    .i_rt_used_id      (i_rt_used_id),
    .o_lu              (w_lu)
  );

  // A jump only counts when the pipeline actually moves; during mem_wait the
  // branch stays in EX and is accepted once memory answers.
  assign w_jumpTaken = (r_state == RUN) & i_jump & ~i_mem_wait;

  // Enable/flush decode. Everything defaults to "frozen, no bubble", which is
  // exactly what mem_wait and an idle HALTED need. In RUN the chain mem_wait >
  // jump > load-use > halt matters: the jump wins because whatever sits in ID
  // is on the wrong path. Load-use and halt share one shape: hold PC and
  // IF/ID, push a bubble into ID/EX, let the older instructions move on.
  always_comb begin
    o_en_pc      = 1'b0;
    o_en_ifid    = 1'b0;
    o_en_idex    = 1'b0;
    o_en_exmem   = 1'b0;
    o_en_memwb   = 1'b0;
    o_flush_ifid = 1'b0;
    o_flush_idex = 1'b0;
    case (r_state)
      RUN: begin
        if (i_mem_wait) begin
          o_en_pc = 1'b0;
        end else if (i_jump) begin
          o_en_pc      = 1'b1;
          o_en_ifid    = 1'b1;
          o_en_idex    = 1'b1;
          o_en_exmem   = 1'b1;
          o_en_memwb   = 1'b1;
          o_flush_ifid = 1'b1;
          o_flush_idex = 1'b1;
        end else if (w_lu || i_halt_id) begin
          o_en_idex    = 1'b1;
          o_en_exmem   = 1'b1;
          o_en_memwb   = 1'b1;
          o_flush_idex = 1'b1;
        end else begin
          o_en_pc    = 1'b1;
          o_en_ifid  = 1'b1;
          o_en_idex  = 1'b1;
          o_en_exmem = 1'b1;
          o_en_memwb = 1'b1;
        end
      end
      DRAIN: begin
        if (!i_mem_wait) begin
          o_en_idex    = 1'b1;
          o_en_exmem   = 1'b1;
          o_en_memwb   = 1'b1;
          o_flush_idex = 1'b1;
        end
      end
      HALTED: begin
        // The held HLT in IF/ID must go, or it would halt us again at once.
        o_flush_ifid = i_restart;
      end
      default: begin
        o_en_pc = 1'b0;
      end
    endcase
  end

  // Later stages never need a bubble today; kept as ports for exceptions.
  assign o_flush_exmem = 1'b0;
  assign o_flush_memwb = 1'b0;

  // Sequencer state, drain counter and the two registered status outputs.
  // HALT is only accepted when nothing above it in priority is active; with a
  // simultaneous load-use the HLT stays in ID and is taken one cycle later.
  // The drain counter runs from DRAIN_CYCLES-1 down to 0 and holds while
  // memory is waiting, so each wait cycle stretches the drain by one.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= RUN;
      r_drainCnt <= '0;
      r_flushed  <= 1'b0;
      r_isHalt   <= 1'b0;
    end else begin
      r_flushed <= w_jumpTaken;
      case (r_state)
        RUN: begin
          if (!i_mem_wait && !i_jump && !w_lu && i_halt_id) begin
            r_state    <= DRAIN;
            r_drainCnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (!i_mem_wait) begin
            if (r_drainCnt == '0) begin
              r_state  <= HALTED;
              r_isHalt <= 1'b1;
            end else begin
              r_drainCnt <= r_drainCnt - DRAIN_ONE;
            end
          end
        end
        HALTED: begin
          if (i_restart) begin
            r_state  <= RUN;
            r_isHalt <= 1'b0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_isHalt <= 1'b0;
        end
      endcase
    end
  end

  assign o_flushed = r_flushed;
  assign o_is_halt = r_isHalt;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic             w_stallEvent;

  // Any cycle lost to load-use or memory wait while the core is live counts
  // as a stall; in HALTED both counters simply hold.
  assign w_stallEvent = (r_state != HALTED) & (w_lu | i_mem_wait);

  // Saturating performance counters.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      r_stallCnt <= satInc(r_stallCnt, w_stallEvent);
      r_flushCnt <= satInc(r_flushCnt, w_jumpTaken);
    end
  end

  assign o_stall_cnt = r_stallCnt;
  assign o_flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl. A behavioural model tracks the
// sequencer mode, the remaining drain cycles and the registered flags, and is
// compared with the DUT on every cycle; directed scenarios add literal checks.
// Optional feature macro: PIPE_PERF_EN (also exercises the counters).
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int DC  = 3;
  localparam int RAW = 3;

  logic           clk = 1'b0;
  logic           resetN;
  logic           jump, memWait, loadEx, regwriteEx;
  logic [RAW-1:0] regwriteAdrEx, rsId, rtId;
  logic           rsUsedId, rtUsedId, haltId, restart;
  logic           enPc, enIfid, enIdex, enExmem, enMemwb;
  logic           flIfid, flIdex, flExmem, flMemwb, flushed, isHalt;
`ifdef PIPE_PERF_EN
  logic [15:0]    stallCnt, flushCnt;
`endif

  int checks   = 0;
  int failures = 0;

  // model: mode 0=running, 1=draining, 2=halted
  int mMode, mDrainLeft, mStall, mFlush;
  bit mFlushed;
  int nMode, nDrainLeft, nStall, nFlush;
  bit nFlushed;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .DRAIN_CYCLES(DC),
    .RA_W        (RAW)
  ) dut (
    .i_clk            (clk),
    .i_reset          (resetN),
    .i_jump           (jump),
    .i_mem_wait       (memWait),
    .i_load_ex        (loadEx),
    .i_regwrite_ex    (regwriteEx),
    .i_regwrite_adr_ex(regwriteAdrEx),
    .i_rs_id          (rsId),
    .i_rt_id          (rtId),
    .i_rs_used_id     (rsUsedId),
    .i_rt_used_id     (rtUsedId),
    .i_halt_id        (haltId),
    .i_restart        (restart),
    .o_en_pc          (enPc),
    .o_en_ifid        (enIfid),
    .o_en_idex        (enIdex),
    .o_en_exmem       (enExmem),
    .o_en_memwb       (enMemwb),
    .o_flush_ifid     (flIfid),
    .o_flush_idex     (flIdex),
    .o_flush_exmem    (flExmem),
    .o_flush_memwb    (flMemwb),
    .o_flushed        (flushed),
    .o_is_halt        (isHalt)
`ifdef PIPE_PERF_EN
    ,
    .o_stall_cnt      (stallCnt),
    .o_flush_cnt      (flushCnt)
`endif
  );

  // Literal comparison helper.
  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mDrainLeft = 0; mFlushed = 0; mStall = 0; mFlush = 0;
    nMode = 0; nDrainLeft = 0; nFlushed = 0; nStall = 0; nFlush = 0;
  endtask

  task automatic applyStimulus(input bit j, input bit mw, input bit ld, input bit rw,
                               input logic [RAW-1:0] adr, input logic [RAW-1:0] rs,
                               input logic [RAW-1:0] rt, input bit rsu, input bit rtu,
                               input bit hlt, input bit rst);
    jump = j; memWait = mw; loadEx = ld; regwriteEx = rw;
    regwriteAdrEx = adr; rsId = rs; rtId = rt;
    rsUsedId = rsu; rtUsedId = rtu; haltId = hlt; restart = rst;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
  endtask

  // Waits for the falling edge, compares every output with the model and
  // works out what the model will look like after the next rising edge.
  task automatic checkOutput();
    logic [10:0] exp, care, act;
    bit lu;
    @(negedge clk);
    lu = loadEx && regwriteEx &&
         ((rsUsedId && rsId == regwriteAdrEx) || (rtUsedId && rtId == regwriteAdrEx));
    exp = '0;
    nMode = mMode; nDrainLeft = mDrainLeft; nFlushed = 0;
    nStall = mStall; nFlush = mFlush;
    if (mMode == 0) begin
      if (memWait) begin
        exp = '0;
      end else if (jump) begin
        exp[10:6] = 5'b11111; exp[5] = 1; exp[4] = 1;
        nFlushed = 1;
        nFlush = (mFlush < 65535) ? mFlush + 1 : mFlush;
      end else if (lu || haltId) begin
        exp[7] = 1; exp[6] = 1; exp[4] = 1;
        if (!lu) begin nMode = 1; nDrainLeft = DC; end
      end else begin
        exp[10:6] = 5'b11111;
      end
    end else if (mMode == 1) begin
      if (!memWait) begin
        exp[7] = 1; exp[6] = 1; exp[4] = 1;
        nDrainLeft = mDrainLeft - 1;
        if (nDrainLeft == 0) nMode = 2;
      end
    end else begin
      if (restart) begin exp[5] = 1; nMode = 0; end
    end
    if (mMode != 2 && (lu || memWait)) nStall = (mStall < 65535) ? mStall + 1 : mStall;
    exp[1] = mFlushed;
    exp[0] = (mMode == 2);
    // the enable of a register being flushed does not matter
    care = '1;
    care[9] = !exp[5];
    care[8] = !exp[4];
    act = {enPc, enIfid, enIdex, enExmem, enMemwb, flIfid, flIdex, flExmem, flMemwb,
           flushed, isHalt};
    checks++;
    if (((act ^ exp) & care) !== 11'b0) begin
      failures++;
      $display("[TB] FAIL outputs: got %b expected %b care %b mode %0d at %0t",
               act, exp, care, mMode, $time);
    end
`ifdef PIPE_PERF_EN
    checkVal("stallCnt", int'(stallCnt), mStall);
    checkVal("flushCnt", int'(flushCnt), mFlush);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    mMode = nMode; mDrainLeft = nDrainLeft; mFlushed = nFlushed;
    mStall = nStall; mFlush = nFlush;
  endtask

  task automatic cycle();
    checkOutput();
    advance();
  endtask

  // Sends a HLT, then counts cycles after the sampling edge until is_halt is
  // seen. Memory wait is held for the first 'waits' drain cycles.
  task automatic haltRun(input int waits, input int expCycles, input string name);
    int found;
    found = -1;
    applyStimulus(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0);
    cycle();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, (k < waits), 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
      checkOutput();
      if (isHalt === 1'b1) begin
        found = k;
        break;
      end
      advance();
    end
    checkVal(name, found, expCycles);
    if (found >= 0) advance();
  endtask

  task automatic restartRun();
    applyStimulus(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1);
    checkOutput();
    checkVal("restart flush_ifid", flIfid, 1);
    checkVal("restart en_pc", enPc, 0);
    checkVal("restart is_halt still", isHalt, 1);
    advance();
    applyIdle();
    checkOutput();
    checkVal("after restart is_halt", isHalt, 0);
    checkVal("after restart en_pc", enPc, 1);
    advance();
  endtask

  initial begin
    logic [RAW-1:0] a, s, t;
    resetN = 1'b0;
    applyIdle();
    modelReset();
    #12 resetN = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    applyIdle();
    checkOutput();
    checkVal("reset en_pc", enPc, 1);
    checkVal("reset flush_idex", flIdex, 0);
    checkVal("reset is_halt", isHalt, 0);
    checkVal("reset flushed", flushed, 0);
    advance();

    // load-use: one stall cycle, then normal flow with a bubble in EX
    applyStimulus(0, 0, 1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0);
    checkOutput();
    checkVal("lu en_pc", enPc, 0);
    checkVal("lu en_ifid", enIfid, 0);
    checkVal("lu flush_idex", flIdex, 1);
    advance();
    applyIdle();
    checkOutput();
    checkVal("post lu en_pc", enPc, 1);
    checkVal("post lu flush_idex", flIdex, 0);
    advance();

    // jump beats load-use and halt
    applyStimulus(1, 0, 1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 1, 0);
    checkOutput();
    checkVal("jump flush_ifid", flIfid, 1);
    checkVal("jump flush_idex", flIdex, 1);
    checkVal("jump en_pc", enPc, 1);
    advance();
    applyIdle();
    checkOutput();
    checkVal("flushed pulse", flushed, 1);
    checkVal("no drain after jump", enPc, 1);
    advance();

    // halt timing, then restart; again with two wait cycles in the drain
    haltRun(0, 3, "halt latency");
    restartRun();
    haltRun(2, 5, "halt latency with wait");
    restartRun();

    // async reset in the middle of a drain
    applyStimulus(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0);
    cycle();
    applyIdle();
    cycle();
    resetN = 1'b0;
    modelReset();
    #1;
    checkVal("mid-drain reset en_pc", enPc, 1);
    checkVal("mid-drain reset flush_idex", flIdex, 0);
    checkVal("mid-drain reset is_halt", isHalt, 0);
    #2 resetN = 1'b1;
    applyIdle();
    cycle();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      a = 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 99) < 30) ? a : 3'($urandom_range(0, 7));
      t = ($urandom_range(0, 99) < 30) ? a : 3'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 70,
                    a, s, t, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 30);
      cycle();
    end

`ifdef PIPE_PERF_EN
    // counter checks from a clean reset
    @(negedge clk);
    resetN = 1'b0;
    modelReset();
    #2 resetN = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
      cycle();
    end
    applyIdle();
    checkOutput();
    checkVal("flush_cnt after 5 jumps", int'(flushCnt), 5);
    advance();
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
      cycle();
    end
    applyIdle();
    checkOutput();
    checkVal("stall_cnt saturated", int'(stallCnt), 65535);
    advance();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
